// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
package updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Out-of-range load values pin to the top of the count range.
    function automatic logic [63:0] clamp_load(input logic [63:0] value,
                                               input logic [63:0] modulo);
        return (value >= modulo) ? (modulo - 64'd1) : value;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Tick generator: one tick per PRESCALE enabled clocks, phase frozen while en=0.
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] RELOAD = 16'(PRESCALE - 1);

    logic [15:0] remain_q, remain_d;

    // Down-counter reaching zero marks the last clock of a prescale period.
    assign tick = en && (remain_q == 16'd0);

    always_comb begin
        remain_d = remain_q;
        if (clr || tick) begin
            remain_d = RELOAD;
        end else if (en) begin
            remain_d = remain_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remain_q <= RELOAD;
        end else begin
            remain_q <= remain_d;
        end
    end

endmodule

// File: rtl/updown_counter_n.sv
// Prescaled modulo-MODULO up/down counter with load, terminal-count decode and wrap pulse.
// Define UPDOWN_COUNTER_SATURATE_EN to make the counter stop at the terminal value instead of wrapping.
module updown_counter_n
    import updown_counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULO   = 16,
    parameter int              PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULO - 1);
`ifdef UPDOWN_COUNTER_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic             at_term;

    counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (t),
        .tick (tick)
    );

    assign at_term = (up == DIR_UP) ? (q_q == TERM) : (q_q == '0);
    assign tc      = at_term;
    assign count   = TERM - q_q;
    assign q       = q_q;
    assign wrap    = wrap_q;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (load) begin
            q_d = WIDTH'(clamp_load(64'(load_val), 64'(MODULO)));
        end else if (tick) begin
            if (at_term) begin
                if (!SATURATE) begin
                    q_d    = (up == DIR_UP) ? '0 : TERM;
                    wrap_d = 1'b1;
                end
            end else if (up == DIR_UP) begin
                q_d = q_q + WIDTH'(1);
            end else begin
                q_d = q_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboard bench: two counters (PRESCALE 1 and 3, MODULO 10) against an arithmetic reference model.
module tb_updown_counter_n;

    localparam int M = 10;
`ifdef UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, t = 1'b0, up = 1'b1, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] q0, q1, cnt0, cnt1;
    logic       tc0, tc1, wrap0, wrap1;

    updown_counter_n #(.WIDTH(4), .MODULO(M), .PRESCALE(1)) dut0 (
        .clk(clk), .rst(rst), .t(t), .up(up), .load(load), .load_val(load_val),
        .q(q0), .count(cnt0), .tc(tc0), .wrap(wrap0));

    updown_counter_n #(.WIDTH(4), .MODULO(M), .PRESCALE(3)) dut1 (
        .clk(clk), .rst(rst), .t(t), .up(up), .load(load), .load_val(load_val),
        .q(q1), .count(cnt1), .tc(tc1), .wrap(wrap1));

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] cnt;
        logic       tc;
        logic       wrap;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: count value, enabled clocks since last step, last-cycle wrap.
    int   mq[2];
    int   mph[2];
    bit   mw[2];
    int   pres[2];

    task automatic chk(input string name, input int d, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, d, $time, act, exp);
        end
    endtask

    task automatic model_step(input int d, input bit r, input bit tt, input bit u,
                              input bit ld, input int lv);
        bit tick;
        tick = 1'b0;
        mw[d] = 1'b0;
        if (r) begin
            mq[d]  = 0;
            mph[d] = 0;
        end else if (ld) begin
            mq[d]  = (lv >= M) ? M - 1 : lv;
            mph[d] = 0;
        end else begin
            if (tt) begin
                mph[d] = mph[d] + 1;
                if (mph[d] == pres[d]) begin
                    tick   = 1'b1;
                    mph[d] = 0;
                end
            end
            if (tick) begin
                if (u && mq[d] == M - 1) begin
                    if (!SAT) begin mq[d] = 0; mw[d] = 1'b1; end
                end else if (!u && mq[d] == 0) begin
                    if (!SAT) begin mq[d] = M - 1; mw[d] = 1'b1; end
                end else begin
                    mq[d] = u ? mq[d] + 1 : mq[d] - 1;
                end
            end
        end
    endtask

    function automatic exp_t expect_of(input int d, input bit u);
        exp_t e;
        e.q    = 4'(mq[d]);
        e.cnt  = 4'(M - 1 - mq[d]);
        e.tc   = (u && mq[d] == M - 1) || (!u && mq[d] == 0);
        e.wrap = mw[d];
        return e;
    endfunction

    task automatic cycle(input bit r, input bit tt, input bit u, input bit ld, input int lv);
        @(negedge clk);
        rst = r; t = tt; up = u; load = ld; load_val = 4'(lv);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) model_step(d, r, tt, u, ld, lv);
        sb0.push_back(expect_of(0, u));
        sb1.push_back(expect_of(1, u));
    endtask

    always @(posedge clk) begin
        #2;
        if (sb0.size() > 0) begin
            e0 = sb0.pop_front();
            chk("q", 0, q0, e0.q);
            chk("count", 0, cnt0, e0.cnt);
            chk("tc", 0, tc0, e0.tc);
            chk("wrap", 0, wrap0, e0.wrap);
        end
        if (sb1.size() > 0) begin
            e1 = sb1.pop_front();
            chk("q", 1, q1, e1.q);
            chk("count", 1, cnt1, e1.cnt);
            chk("tc", 1, tc1, e1.tc);
            chk("wrap", 1, wrap1, e1.wrap);
        end
    end

    initial begin
        pres[0] = 1; pres[1] = 3;
        for (int d = 0; d < 2; d++) begin mq[d] = 0; mph[d] = 0; mw[d] = 1'b0; end

        cycle(1, 0, 1, 0, 0);
        cycle(1, 1, 1, 1, 5);
        for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 3);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 1, 13);
        cycle(0, 1, 1, 1, 5);
        cycle(0, 0, 1, 0, 0);

        // Prescale gap: 4 enabled clocks, 2 idle, 5 enabled.
        cycle(1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, 0);

        // Reset mid-phase and mid-load.
        cycle(0, 0, 1, 1, 7);
        cycle(0, 1, 1, 0, 0);
        cycle(1, 1, 1, 1, 2);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0);

        // Run into the terminal value, then reverse direction.
        cycle(1, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) != 0 ? up : ~up,
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));
        end

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drain", 0, sb0.size(), 0);
        chk("scoreboard_drain", 1, sb1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/updown_counter_n.md
UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MODULO, default 16: count modulus, legal range 2..2**WIDTH.
REQ-003 SHALL have parameter PRESCALE, default 1: enabled clocks per count step, legal range 1..65535.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port t, input, 1 bit: count enable.
REQ-007 SHALL have port up, input, 1 bit: direction select, 1 counts up, 0 counts down.
REQ-008 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 SHALL have port load_val, input, WIDTH bits: value to load.
REQ-010 SHALL have port q, output, WIDTH bits: registered count value.
REQ-011 SHALL have port count, output, WIDTH bits: remaining count, equal to MODULO-1-q, combinational.
REQ-012 SHALL have port tc, output, 1 bit: terminal-count decode, combinational.
REQ-013 SHALL have port wrap, output, 1 bit: registered single-cycle wrap pulse.

Function
REQ-014 Update priority SHALL be: rst, then load, then count step.
REQ-015 A count step SHALL occur only on a clock where the prescaler tick is high; the tick SHALL be high once per PRESCALE consecutive clocks with t=1.
REQ-016 When PRESCALE=1, tick SHALL equal t.
REQ-017 The prescaler SHALL hold its phase while t=0, and SHALL clear to phase 0 on rst or load.
REQ-018 Up step: q SHALL become q+1, or 0 when q==MODULO-1.
REQ-019 Down step: q SHALL become q-1, or MODULO-1 when q==0.
REQ-020 Load SHALL set q to load_val, or to MODULO-1 if load_val>=MODULO; load SHALL never produce a wrap pulse.
REQ-021 tc SHALL be 1 when (up and q==MODULO-1) or (!up and q==0), independent of t.
REQ-022 wrap SHALL be 1 for exactly the one cycle following a step that crossed the terminal value; it SHALL be 0 otherwise.
REQ-023 A change of up SHALL take effect on the very next step; the prescaler phase SHALL NOT be disturbed by it.
REQ-024 q SHALL never hold a value >= MODULO.

Reset
REQ-025 On a clock with rst=1: q SHALL be 0, wrap 0, and prescaler phase 0.
REQ-026 Reset SHALL apply mid-prescale and mid-load, overriding t and load on the same clock.
REQ-027 Immediately after reset, with up=1: count SHALL be MODULO-1 and tc SHALL be 0.

Configuration
REQ-028 Macro UPDOWN_COUNTER_SATURATE_EN SHALL select saturating mode.
- Defined: a step at the terminal value SHALL leave q unchanged and wrap SHALL stay 0.
- Undefined: modulo wrap-around per REQ-018/019, and the wrap port SHALL be driven.

Structure
REQ-029 Package updown_counter_pkg SHALL hold direction constants DIR_UP=1 and DIR_DOWN=0, plus a function clamp_load(value, modulo).
REQ-030 Sub-module counter_prescaler SHALL implement the tick generator: inputs clk, rst, clr, en; output tick; parameter PRESCALE.

Verification (WIDTH=4, MODULO=10, PRESCALE=1 unless stated)
REQ-031 rst=1 then t=1, up=1 for 12 clocks -> q runs 0..9, 0, 1; wrap high for 1 cycle after 9->0; tc high while q==9.
REQ-032 Load 3, then up=0 for 5 steps -> q = 2, 1, 0, 9, 8; wrap pulse after 0->9; tc high at q==0.
REQ-033 load_val=13 -> q=9, no wrap; load and t asserted together -> load wins, no step.
REQ-034 PRESCALE=3, t=1 for 9 clocks with t=0 for 2 clocks inserted after clock 4 -> exactly 3 steps, phase held across the gap.
REQ-035 rst asserted while q=7 and prescaler mid-phase -> next cycle q=0, wrap=0, full PRESCALE clocks before the next step.
REQ-036 UPDOWN_COUNTER_SATURATE_EN defined, up=1, 15 steps -> q stops at 9, wrap never asserts; then up=0 -> q=8 on the next step.
